// File: rtl/pll_rst_pkg.sv
// PLL reset supervisor: shared state type,
// default timing constants and counter sizing.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_e;

  localparam int unsigned DEF_RST_CYCLES   = 64;
  localparam int unsigned DEF_STABLE_CYC   = 1024;
  localparam int unsigned DEF_TIMEOUT_CYC  = 500000;
  localparam int unsigned DEF_RETRY_W      = 8;

  function automatic int unsigned cnt_w(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_rst_ctrl_sync2.sv
// Two-flop synchronizer for a single
// asynchronous level, cleared by reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset and lock supervisor: holds the
// PLL in reset, waits for stable lock, retries.
module pll_rst_ctrl
  import pll_rst_pkg::*;
#(
  parameter int unsigned RST_CYCLES          = DEF_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_TIMEOUT_CYC,
  parameter int unsigned RETRY_W             = DEF_RETRY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned CW = cnt_w(
    RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

  localparam logic [CW-1:0] RST_LAST =
    CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  state_e        state;
  logic [CW-1:0] cnt;
  logic          lock_s;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  function automatic logic [RETRY_W-1:0] sat_inc(
    input logic [RETRY_W-1:0] v
  );
    return (v == RETRY_MAX) ? v : v + RETRY_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= '0;
    end else begin
      lock_lost <= 1'b0;
      cnt       <= cnt + CW'(1);
      unique case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            retry_cnt <= sat_inc(retry_cnt);
          end
        end
        STABLE: begin
          // a glitch restarts the wait, not the PLL
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end
        end
        RUN: begin
          cnt <= '0;
          if (!lock_s) begin
            state     <= RESET_PLL;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
            retry_cnt <= sat_inc(retry_cnt);
          end
        end
        default: begin
          state <= RESET_PLL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scoreboard bench for pll_rst_ctrl: expected
// output changes are queued with their edge number.
module tb_pll_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [2:0] retry_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = -1;

  typedef struct {
    int         cyc;
    logic [6:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];

  localparam logic [6:0] RST_V = 7'b1000000;

  always #5 clk = ~clk;

  pll_rst_ctrl #(
    .RST_CYCLES          (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .RETRY_W             (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt)
  );

  wire [6:0] cur = {pll_reset, sys_rst_n, ready,
                    lock_lost, retry_cnt};

  // edge index: after edge k following release, cyc == k
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= -1;
    else cyc <= cyc + 1;

  function automatic logic [6:0] b(
    input logic pr, input logic s, input logic r,
    input logic l, input int rc
  );
    logic [2:0] c;
    c = 3'(rc);
    return {pr, s, r, l, c};
  endfunction

  task automatic push(input int c, input logic [6:0] v,
                      input string t);
    exp_t e;
    e.cyc = c;
    e.v = v;
    e.tag = t;
    q.push_back(e);
  endtask

  // monitor: every output change must match the queue head
  initial begin
    logic [6:0] last;
    exp_t e;
    last = RST_V;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = cur;
      end else if (cur !== last) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b prev=%b",
                   cyc, cur, last);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.v !== cur) begin
            errors++;
            $display("FAIL %s got cyc=%0d val=%b required cyc=%0d val=%b",
                     e.tag, cyc, cur, e.cyc, e.v);
          end
        end
        last = cur;
      end
    end
  end

  task automatic wait_cyc(input int c);
    int i;
    i = 0;
    while (cyc < c && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (cyc < c) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout got cyc=%0d required cyc=%0d", cyc, c);
    end
  endtask

  task automatic start(input logic lock, input string t);
    #1 rst_n = 1'b0;
    pll_lock = lock;
    #1;
    checks++;
    if (cur !== RST_V) begin
      errors++;
      $display("FAIL %s_reset_vals got=%b required=%b", t, cur, RST_V);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic finish_scen(input int c, input string t);
    wait_cyc(c);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got=%0d required=0 (head %s)",
               t, q.size(), q[0].tag);
      q.delete();
    end
  endtask

  initial begin
    // 1: lock high throughout
    push(3,  b(0,0,0,0,0), "s1_prst_fall");
    push(12, b(0,1,1,0,0), "s1_release");
    start(1'b1, "s1");
    finish_scen(30, "s1");

    // 2: lock stuck low, retries saturate at 7
    push(3, b(0,0,0,0,0), "s2_prst_fall");
    for (int n = 1; n <= 9; n++) begin
      push(35 + 36*(n-1), b(1,0,0,0,(n > 7) ? 7 : n), "s2_retry");
      push(39 + 36*(n-1), b(0,0,0,0,(n > 7) ? 7 : n), "s2_prst_fall");
    end
    start(1'b0, "s2");
    finish_scen(330, "s2");

    // 3: one-cycle glitch during STABLE
    push(3,  b(0,0,0,0,0), "s3_prst_fall");
    push(26, b(0,1,1,0,0), "s3_release");
    start(1'b0, "s3");
    wait_cyc(9);
    pll_lock = 1'b1;
    wait_cyc(14);
    pll_lock = 1'b0;
    wait_cyc(15);
    pll_lock = 1'b1;
    finish_scen(40, "s3");

    // 4: lock loss in RUN
    push(3,  b(0,0,0,0,0), "s4_prst_fall");
    push(12, b(0,1,1,0,0), "s4_release");
    push(18, b(1,0,0,1,1), "s4_lock_lost");
    push(19, b(1,0,0,0,1), "s4_pulse_end");
    push(22, b(0,0,0,0,1), "s4_prst_fall2");
    push(31, b(0,1,1,0,1), "s4_rerelease");
    start(1'b1, "s4");
    wait_cyc(15);
    pll_lock = 1'b0;
    wait_cyc(18);
    pll_lock = 1'b1;
    finish_scen(45, "s4");

    // 5: reset while in STABLE with two retries
    push(3,  b(0,0,0,0,0), "s5_prst_fall");
    push(35, b(1,0,0,0,1), "s5_retry1");
    push(39, b(0,0,0,0,1), "s5_prst_fall1");
    push(71, b(1,0,0,0,2), "s5_retry2");
    push(75, b(0,0,0,0,2), "s5_prst_fall2");
    start(1'b0, "s5");
    wait_cyc(76);
    pll_lock = 1'b1;
    finish_scen(82, "s5");
    push(3,  b(0,0,0,0,0), "s5b_prst_fall");
    push(12, b(0,1,1,0,0), "s5b_release");
    start(1'b1, "s5_async");
    finish_scen(30, "s5b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
